uart_cmd_ctrl: RTL

UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

---
 rtl/uart_cmd_pkg.sv | 23 ++
 rtl/uart_cmd_timer.sv | 35 +++
 rtl/uart_cmd_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command-frame controller: FSM encoding,
// error codes, frame constants and payload sizing.
package uart_cmd_pkg;

   typedef enum logic [2:0] {
      StIdle = 3'd0,
      StOpc  = 3'd1,
      StLen  = 3'd2,
      StData = 3'd3,
      StCsum = 3'd4,
      StHold = 3'd5
   } state_e;

   localparam logic [1:0] ErrCsum    = 2'd0;
   localparam logic [1:0] ErrLen     = 2'd1;
   localparam logic [1:0] ErrTimeout = 2'd2;
   localparam logic [1:0] ErrOverrun = 2'd3;

   localparam logic [7:0]  SofByte  = 8'hA5;
   localparam int unsigned MaxLen   = 8;
   localparam int unsigned PayloadW = 64;

endpackage

// File: rtl/uart_cmd_timer.sv
// Inter-byte timeout counter. Counts while enabled, restarts on clear or when
// disabled, and flags expiry once the count reaches TIMEOUT_CLKS-1.
// Only instantiated when UART_CMD_TIMEOUT_EN is defined.
module uart_cmd_timer #(
   parameter int unsigned TIMEOUT_CLKS = 4340
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned    CntW    = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CLKS - 1);

   logic [CntW-1:0] r_cnt;

   // Counter: restart on clear/disable, saturate at the expiry value
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (clear || !enable) begin
         r_cnt <= '0;
      end else if (!expired) begin
         r_cnt <= r_cnt + CntW'(1);
      end
   end

   // Expiry flag decoded from the count
   always_comb begin
      expired = (r_cnt == LastCnt);
   end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART command-frame controller. Parses SOF, OPCODE, LEN, payload, CSUM from a
// byte stream, holds a checksum-good command until the consumer accepts it,
// and reports checksum/length/timeout/overrun errors as single-cycle pulses.
// Optional inter-byte timeout: define UART_CMD_TIMEOUT_EN.
module uart_cmd_ctrl
   import uart_cmd_pkg::*;
#(
   parameter int unsigned MAX_LEN      = MaxLen,
   parameter int unsigned TIMEOUT_CLKS = 4340
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [7:0]          rx_data,
   input  logic                rx_valid,
   input  logic                cmd_ready,
   output logic                cmd_valid,
   output logic [7:0]          cmd_opcode,
   output logic [3:0]          cmd_len,
   output logic [PayloadW-1:0] cmd_payload,
   output logic                err_pulse,
   output logic [1:0]          err_code
);

   // Parameter sanity: payload port holds at most PayloadW/8 bytes
   if (MAX_LEN > PayloadW / 8) begin : g_bad_max_len
      $error("MAX_LEN exceeds payload capacity");
   end
   if (TIMEOUT_CLKS < 2) begin : g_bad_timeout
      $error("TIMEOUT_CLKS must be at least 2");
   end

   localparam logic [7:0] MaxLenB = 8'(MAX_LEN);

   state_e              r_state;
   state_e              w_state_nxt;
   logic [7:0]          r_opcode;
   logic [3:0]          r_len;
   logic [PayloadW-1:0] r_payload;
   logic [7:0]          r_xor;
   logic [2:0]          r_idx;
   logic                r_err_pulse;
   logic [1:0]          r_err_code;

   logic                w_err_fire;
   logic [1:0]          w_err_code;
   logic                w_last_byte;
   logic                w_timeout;

`ifdef UART_CMD_TIMEOUT_EN
   logic w_in_frame;
   logic w_expired;

   assign w_in_frame = (r_state == StOpc) || (r_state == StLen) ||
                       (r_state == StData) || (r_state == StCsum);

   uart_cmd_timer #(
      .TIMEOUT_CLKS (TIMEOUT_CLKS)
   ) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (rx_valid),
      .enable  (w_in_frame),
      .expired (w_expired)
   );

   // A byte arriving on the expiry edge wins over the timeout
   assign w_timeout = w_expired && w_in_frame && !rx_valid;
`else
   assign w_timeout = 1'b0;
`endif

   assign w_last_byte = ({1'b0, r_idx} == (r_len - 4'd1));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and error decode
   always_comb begin
      w_state_nxt = r_state;
      w_err_fire  = 1'b0;
      w_err_code  = r_err_code;
      if (w_timeout) begin
         w_state_nxt = StIdle;
         w_err_fire  = 1'b1;
         w_err_code  = ErrTimeout;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (rx_valid && (rx_data == SofByte)) begin
                  w_state_nxt = StOpc;
               end
            end
            StOpc: begin
               if (rx_valid) begin
                  w_state_nxt = StLen;
               end
            end
            StLen: begin
               if (rx_valid) begin
                  if (rx_data > MaxLenB) begin
                     w_state_nxt = StIdle;
                     w_err_fire  = 1'b1;
                     w_err_code  = ErrLen;
                  end else if (rx_data == 8'd0) begin
                     w_state_nxt = StCsum;
                  end else begin
                     w_state_nxt = StData;
                  end
               end
            end
            StData: begin
               if (rx_valid && w_last_byte) begin
                  w_state_nxt = StCsum;
               end
            end
            StCsum: begin
               if (rx_valid) begin
                  if (rx_data == r_xor) begin
                     w_state_nxt = StHold;
                  end else begin
                     w_state_nxt = StIdle;
                     w_err_fire  = 1'b1;
                     w_err_code  = ErrCsum;
                  end
               end
            end
            StHold: begin
               // Overrun is flagged even when the handshake completes this cycle
               if (rx_valid) begin
                  w_err_fire = 1'b1;
                  w_err_code = ErrOverrun;
               end
               if (cmd_ready) begin
                  w_state_nxt = StIdle;
               end
            end
            default: begin
               w_state_nxt = StIdle;
            end
         endcase
      end
   end

   // Frame datapath: opcode, length, payload slots and running XOR
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_opcode  <= '0;
         r_len     <= '0;
         r_payload <= '0;
         r_xor     <= '0;
         r_idx     <= '0;
      end else if (rx_valid) begin
         case (r_state)
            StIdle: begin
               if (rx_data == SofByte) begin
                  r_payload <= '0;
                  r_xor     <= '0;
                  r_idx     <= '0;
               end
            end
            StOpc: begin
               r_opcode <= rx_data;
               r_xor    <= rx_data;
            end
            StLen: begin
               r_xor <= r_xor ^ rx_data;
               if (rx_data <= MaxLenB) begin
                  r_len <= rx_data[3:0];
               end
            end
            StData: begin
               r_payload[{r_idx, 3'b000} +: 8] <= rx_data;
               r_xor                           <= r_xor ^ rx_data;
               r_idx                           <= r_idx + 3'd1;
            end
            default: begin
            end
         endcase
      end
   end

   // Error strobe and sticky error code
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_pulse <= 1'b0;
         r_err_code  <= '0;
      end else begin
         r_err_pulse <= w_err_fire;
         if (w_err_fire) begin
            r_err_code <= w_err_code;
         end
      end
   end

   // Outputs driven from registered state only
   always_comb begin
      cmd_valid   = (r_state == StHold);
      cmd_opcode  = r_opcode;
      cmd_len     = r_len;
      cmd_payload = r_payload;
      err_pulse   = r_err_pulse;
      err_code    = r_err_code;
   end

endmodule
